// File: rtl/issue_ctl.sv
// In-order issue controller: RAW hazard check against in-flight destinations,
// NOP bubble insertion, pipe advance and drain. Define ISSUE_STATS_EN for issue/stall counters.
module issue_ctl #(
  parameter int WIDTH = 32,
  parameter int LAT   = $clog2(WIDTH) - 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_ins,
  output logic        ex_start,
  output logic [2:0]  ex_opcode,
  output logic [4:0]  ex_Rs1,
  output logic [4:0]  ex_Rs2,
  output logic [4:0]  ex_Rd,
  output logic [11:0] ex_imm,
  output logic        busy,
  output logic [15:0] issue_cnt,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [LAT-1:0][4:0]    r_dq;

  logic [2:0]  w_op;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_src1;
  logic [4:0]  w_src2;
  logic        w_legal;
  logic        w_hazard;
  logic        w_dq_any;
  logic        w_accept;
  logic        w_unused;

  assign w_op     = in_ins[2:0];
  assign w_rs1    = in_ins[7:3];
  assign w_rs2    = in_ins[17:13];
  assign w_legal  = ~w_op[2];
  assign w_unused = ^in_ins[31:25];

  // Only fields the opcode actually reads are compared; r0 reads never hazard.
  assign w_src1 = (w_op == 3'b001 || w_op == 3'b010 || w_op == 3'b011) ? w_rs1 : 5'd0;
  assign w_src2 = (w_op == 3'b001 || w_op == 3'b010) ? w_rs2 : 5'd0;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_hazard = 1'b0;
    w_dq_any = 1'b0;
    if (w_src1 != 5'd0 && w_src1 == ex_Rd) w_hazard = 1'b1;
    if (w_src2 != 5'd0 && w_src2 == ex_Rd) w_hazard = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      if (r_dq[i] != 5'd0) w_dq_any = 1'b1;
      if (w_src1 != 5'd0 && w_src1 == r_dq[i]) w_hazard = 1'b1;
      if (w_src2 != 5'd0 && w_src2 == r_dq[i]) w_hazard = 1'b1;
    end
  end

  assign busy     = (ex_opcode != 3'd0) || (ex_Rd != 5'd0) || w_dq_any;
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_state_nxt = r_state;
    ex_start    = 1'b0;
    in_ready    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (en) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        ex_start = 1'b1;
        in_ready = ~w_hazard;
        if (!en)                       w_state_nxt = S_DRAIN;
        else if (in_valid && w_hazard) w_state_nxt = S_STALL;
      end
      S_STALL: begin
        ex_start = 1'b1;
        in_ready = ~w_hazard;
        if (!en)                        w_state_nxt = S_DRAIN;
        else if (!w_hazard || !in_valid) w_state_nxt = S_RUN;
      end
      S_DRAIN: begin
        ex_start = 1'b1;
        if (en)         w_state_nxt = S_RUN;
        else if (!busy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the tracker is reset along with the state so in-flight work is discarded.
    if (!rst) begin
      r_state   <= S_IDLE;
      ex_opcode <= '0;
      ex_Rs1    <= '0;
      ex_Rs2    <= '0;
      ex_Rd     <= '0;
      ex_imm    <= '0;
      r_dq      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      r_state <= w_state_nxt;
      if (w_accept && w_legal) begin
        ex_opcode <= w_op;
        ex_Rs1    <= w_rs1;
        ex_Rs2    <= w_rs2;
        ex_Rd     <= in_ins[12:8];
        ex_imm    <= in_ins[24:13];
      end else begin
        ex_opcode <= '0;
        ex_Rs1    <= '0;
        ex_Rs2    <= '0;
        ex_Rd     <= '0;
        ex_imm    <= '0;
      end
      if (ex_start) r_dq <= {r_dq[LAT-2:0], ex_Rd};
    end
  end

`ifdef ISSUE_STATS_EN
  logic [15:0] r_issue_cnt;
  logic [15:0] r_stall_cnt;
  logic        w_counted;

  assign w_counted = w_legal && (w_op != 3'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_accept && w_counted && r_issue_cnt != 16'hFFFF) r_issue_cnt <= r_issue_cnt + 16'd1;
      if (r_state == S_STALL && r_stall_cnt != 16'hFFFF)    r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign issue_cnt = r_issue_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  assign issue_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_issue_ctl.sv
// Directed bench for issue_ctl: reset, independent stream, RAW stall, source corners,
// drain and reset mid-stall. Counter expectations follow ISSUE_STATS_EN.
module tb_issue_ctl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ins;
  logic        ex_start;
  logic [2:0]  ex_opcode;
  logic [4:0]  ex_Rs1;
  logic [4:0]  ex_Rs2;
  logic [4:0]  ex_Rd;
  logic [11:0] ex_imm;
  logic        busy;
  logic [15:0] issue_cnt;
  logic [15:0] stall_cnt;

  int  n_vec  = 0;
  int  n_miss = 0;
  bit  clk_on = 1'b0;

  issue_ctl dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ins    (in_ins),
    .ex_start  (ex_start),
    .ex_opcode (ex_opcode),
    .ex_Rs1    (ex_Rs1),
    .ex_Rs2    (ex_Rs2),
    .ex_Rd     (ex_Rd),
    .ex_imm    (ex_imm),
    .busy      (busy),
    .issue_cnt (issue_cnt),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    wait (clk_on);
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] ins(input logic [2:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {14'd0, rs2, rd, rs1, op};
  endfunction

  function automatic logic [31:0] stat(input int v);
`ifdef ISSUE_STATS_EN
    return 32'(v);
`else
    return 32'(v * 0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, {31'd0, ex_start}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy},     32'd0);
    chk({tag, "_exf"},   {4'd0, ex_opcode, ex_Rs1, ex_Rs2, ex_Rd, ex_imm}, 32'd0);
    chk({tag, "_cnts"},  {issue_cnt, stall_cnt}, 32'd0);
  endtask

  task automatic send(input string tag, input logic [31:0] w);
    in_ins   = w;
    in_valid = 1'b1;
    #1;
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    tick();
  endtask

  // Producer ADD r3=r1+r2 then dependent MULT r4=r3*r3; MULT must land 6 edges later.
  task automatic raw_pair(input string tag, input int exp_issue);
    int   k;
    logic bad;
    send({tag, "_add"}, ins(3'b001, 5'd3, 5'd1, 5'd2));
    in_ins = ins(3'b010, 5'd4, 5'd3, 5'd3);
    #1;
    k   = 0;
    bad = 1'b0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
      if ({ex_opcode, ex_Rs1, ex_Rs2, ex_Rd, ex_imm} != '0) bad = 1'b1;
    end
    tick();
    chk({tag, "_edges"},  32'(k + 1), 32'd6);
    chk({tag, "_bubble"}, {31'd0, bad}, 32'd0);
    chk({tag, "_mult"},   {19'd0, ex_opcode, ex_Rd, ex_Rs1}, {19'd0, 3'b010, 5'd4, 5'd3});
    in_valid = 1'b0;
    chk({tag, "_stall_cnt"}, {16'd0, stall_cnt}, stat(5));
    chk({tag, "_issue_cnt"}, {16'd0, issue_cnt}, stat(exp_issue));
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    en       = 1'b0;
    in_valid = 1'b0;
    in_ins   = '0;

    // Reset with no clock running.
    #2 rst = 1'b0;
    #1 chk_all_zero("reset");
    #2 rst = 1'b1;
    en     = 1'b1;
    #1;
    chk("idle_start", {31'd0, ex_start}, 32'd0);
    clk_on = 1'b1;
    tick();
    chk("run_start", {31'd0, ex_start}, 32'd1);
    chk("run_ready", {31'd0, in_ready}, 32'd1);

    // Independent stream, one acceptance per cycle.
    send("s1", ins(3'b001, 5'd1, 5'd2, 5'd3));
    chk("s1_ex", {16'd0, ex_opcode, ex_Rd, ex_Rs1, ex_Rs2}, {16'd0, 3'b001, 5'd1, 5'd2, 5'd3});
    send("s2", ins(3'b001, 5'd4, 5'd5, 5'd6));
    send("s3", ins(3'b010, 5'd7, 5'd8, 5'd9));
    chk("s3_ex", {16'd0, ex_opcode, ex_Rd, ex_Rs1, ex_Rs2}, {16'd0, 3'b010, 5'd7, 5'd8, 5'd9});
    send("s4", ins(3'b011, 5'd10, 5'd11, 5'd5));
    chk("s4_imm", {20'd0, ex_imm}, 32'd5);
    in_valid = 1'b0;
    chk("s_issue_cnt", {16'd0, issue_cnt}, stat(4));
    chk("s_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    tick();
    chk("s_bubble", {4'd0, ex_opcode, ex_Rs1, ex_Rs2, ex_Rd, ex_imm}, 32'd0);
    repeat (6) tick();
    chk("s_quiet", {31'd0, busy}, 32'd0);

    raw_pair("raw1", 6);

    // Source-field corners.
    send("c_add", ins(3'b001, 5'd3, 5'd1, 5'd2));
    send("c_addi", ins(3'b011, 5'd5, 5'd6, 5'd3));
    chk("c_addi_imm", {17'd0, ex_opcode, ex_imm}, {17'd0, 3'b011, 12'd3});
    send("c_rd0", ins(3'b001, 5'd0, 5'd1, 5'd2));
    send("c_r0src", ins(3'b001, 5'd7, 5'd0, 5'd0));
    send("c_ill", ins(3'b101, 5'd9, 5'd3, 5'd0));
    chk("c_ill_ex", {4'd0, ex_opcode, ex_Rs1, ex_Rs2, ex_Rd, ex_imm}, 32'd0);
    in_valid = 1'b0;
    chk("c_issue_cnt", {16'd0, issue_cnt}, stat(10));

    // Drain with two instructions in flight.
    send("d1", ins(3'b001, 5'd12, 5'd13, 5'd14));
    send("d2", ins(3'b010, 5'd15, 5'd16, 5'd17));
    in_valid = 1'b0;
    en       = 1'b0;
    tick();
    chk("d_enter", {29'd0, ex_start, in_ready, busy}, {29'd0, 1'b1, 1'b0, 1'b1});
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk("d_len", {31'd0, (n <= 5) && !busy}, 32'd1);
    chk("d_still_drain", {31'd0, ex_start}, 32'd1);
    tick();
    chk("d_idle", {30'd0, ex_start, in_ready}, 32'd0);

    // Reset in the middle of a stall.
    en = 1'b1;
    tick();
    send("r_add", ins(3'b001, 5'd3, 5'd1, 5'd2));
    in_ins = ins(3'b010, 5'd4, 5'd3, 5'd3);
    tick();
    tick();
    chk("r_stalled", {31'd0, in_ready}, 32'd0);
    #2 rst = 1'b0;
    #1 chk_all_zero("r_reset");
    in_valid = 1'b0;
    #2 rst = 1'b1;
    tick();
    chk("r_run", {31'd0, ex_start}, 32'd1);
    raw_pair("raw2", 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/issue_ctl.md
# issue_ctl

In-order issue controller between the instruction fetch stage and the decode/execute/writeback pipeline (ADD/ADDI/MULT pipes of equal latency sharing one register file). It accepts 32-bit instructions with a valid/ready handshake and checks each one's source registers against all destinations still in flight. On a read-after-write hazard it stalls and issues NOP bubbles. It also drives the pipes' `start` (advance) enable and drains in-flight results before going idle.

## Interface
- `WIDTH`, 32: datapath width of the execute pipes.
- `LAT`, `$clog2(WIDTH)-1`: execute-pipe depth in cycles (4 at WIDTH=32).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `en` in 1: run request.
- `in_valid` in 1: `in_ins` holds an instruction.
- `in_ready` out 1: instruction accepted this cycle when `in_valid & in_ready`.
- `in_ins` in 32: instruction; opcode [2:0], Rs1 [7:3], Rd [12:8], Rs2 [17:13], imm [24:13].
- `ex_start` out 1: advance enable for the execute pipes.
- `ex_opcode` out 3, `ex_Rs1`/`ex_Rs2`/`ex_Rd` out 5, `ex_imm` out 12: issued instruction fields; all zero means bubble.
- `busy` out 1: issued instruction or in-flight destination present.
- `issue_cnt` out 16: accepted non-NOP instructions, saturating.
- `stall_cnt` out 16: cycles spent in STALL, saturating.

## Operation
- Opcodes:
  - 001 ADD: reads Rs1, Rs2.
  - 011 ADDI: reads Rs1 only; bits [17:13] are immediate.
  - 010 MULT: reads Rs1, Rs2.
  - 000 NOP: reads nothing.
  - 1xx: illegal; accepted and issued as NOP, not counted.
- Rd=0 means no write and is never tracked. A source field of 0 never hazards.
- Destination tracker: shift register `dq[0..LAT-1]` of 5-bit Rd values (0 = empty). On each edge with `ex_start`=1: `dq[0]<=ex_Rd`, `dq[i+1]<=dq[i]`, `dq[LAT-1]` retires (its result is written to the register file at that edge).
- Hazard: a read source of `in_ins` equals a nonzero `ex_Rd` or any nonzero `dq[i]`.
- `in_ready` is combinational: state ∈ {RUN, STALL} and no hazard.
- At each edge, on acceptance, ex fields load from `in_ins` (illegal opcode becomes all-zero). Otherwise ex fields load zero. Issue is therefore a one-cycle pulse.
- State machine:
  - IDLE: `ex_start`=0; goes to RUN when `en`.
  - RUN: goes to STALL when `in_valid` and hazard; goes to DRAIN when `!en`.
  - STALL: goes to RUN when the hazard clears or `in_valid` drops; goes to DRAIN when `!en`.
  - DRAIN: no acceptance; goes to RUN when `en`; goes to IDLE when `!busy`.
- `ex_start`=1 in RUN, STALL and DRAIN.
- No WAW or writeback-port conflict can occur: single issue, in order, equal pipe latency.

## Timing
- Reset (async, immediate, no clock required):
  - state IDLE.
  - All ex fields, `dq`, and counters 0.
  - `ex_start`, `in_ready`, `busy` all 0.
  - In-flight work is discarded.
- Accept at edge N: ex fields valid in cycle N..N+1. Tracked in `dq[0]` after edge N+1. Result written at edge N+1+LAT.
- Dependent instruction waiting behind a producer accepted at edge N is accepted no earlier than edge N+LAT+2, i.e. LAT+1 stall cycles (5 at LAT=4).
- Independent instructions: one accepted per cycle.
- `en` low in the same cycle as a hazard: DRAIN wins, no acceptance.
- Drain from a full pipe takes at most LAT+1 cycles.

## Configuration
- `ISSUE_STATS_EN` defined: `issue_cnt` and `stall_cnt` are implemented as above.
- Not defined: both outputs are tied to 0 and no counter flops exist. All other behaviour is identical.

## Test plan
- Reset: pulse `rst` low with no clock → all outputs 0, `in_ready`=0. Then `en`=1 → `ex_start`=1, `in_ready`=1 next cycle.
- Independent stream:
  - Stimulus: ADD r1=r2+r3, ADD r4=r5+r6, MULT r7=r8*r9, ADDI r10=r11+5, back to back.
  - Required: four acceptances in four consecutive cycles; `issue_cnt`=4, `stall_cnt`=0.
- RAW stall:
  - Stimulus: ADD r3=r1+r2, then MULT r4=r3*r3 (LAT=4).
  - Required: MULT accepted exactly 6 edges after ADD; `stall_cnt`=5; bubbles are all-zero.
- Source-field corner cases:
  - ADDI with imm[4:0]=3 following a write to r3 → no stall.
  - ADD reading r0 after any Rd=0 instruction → no stall.
  - Opcode 101 → issued as NOP; `issue_cnt` unchanged.
- Drain: drop `en` with two instructions in flight → state DRAIN, `ex_start`=1, `busy` clears within LAT+1 cycles, then IDLE with `ex_start`=0.
- Reset mid-stall: assert `rst` during STALL → all outputs 0 immediately; after release, a fresh dependent pair behaves as in the RAW stall scenario.
- Build with and without `ISSUE_STATS_EN`: without it, both counters read 0 throughout the independent-stream scenario.
